cpwm_update_sequencer: RTL and testbench
========================================

# cpwm_update_sequencer

Carrier generator and synchronized update sequencer for the 8-channel carrier PWM peripheral. Sits between the AXI4-Lite register bank (which holds shadow period/compare values and issues a commit pulse) and the PWM comparators. Produces a symmetric up-down carrier, snapshots shadow values on commit and applies them atomically only at carrier boundaries, so channel outputs never glitch mid-period.

## Interface
- N_CH, 8, number of PWM channels
- CW, 16, carrier/compare width in bits
- ACLK  in  1  system clock; all logic on rising edge
- ARESETN  in  1  synchronous, active-low reset
- enable  in  1  carrier run; 0 = stopped
- upd_mode  in  1  0 = apply at zero only; 1 = apply at zero and peak (see Configuration)
- period_sh  in  CW  shadow carrier peak value
- cmp_sh  in  N_CH*CW  shadow compares; channel i at [i*CW +: CW]
- commit  in  1  single-cycle request to snapshot shadows
- busy  out  1  snapshot captured, not yet applied
- upd_done  out  1  one-cycle pulse, cycle after apply
- carrier  out  CW  carrier count
- dir  out  1  0 = counting up, 1 = counting down
- period_act  out  CW  active period
- cmp_act  out  N_CH*CW  active compares
- pwm  out  N_CH  channel outputs

## Operation
- Reset (ARESETN=0 at edge): carrier=0, dir=0, period_act=0, cmp_act=0, pwm=0, busy=0, upd_done=0, FSM=IDLE, snapshot regs=0. Reset mid-ARMED discards snapshot.
- Carrier (enable=1): up from 0 to period_act, dir flips to 1 on the cycle carrier reaches period_act, down to 0, dir flips to 0 on reaching 0. Period P gives a 2P-cycle carrier period. period_act=0: carrier holds 0, every cycle is a zero event.
- enable=0: carrier forced to 0, dir to 0 next cycle.
- Events: zero = enable & carrier==0; peak = enable & carrier==period_act & dir==0.
- FSM IDLE: commit -> snapshot period_sh/cmp_sh, go ARMED, busy=1.
- FSM ARMED: apply event -> load period_act/cmp_act from snapshot, go IDLE. Apply event = zero (or peak if enabled and upd_mode=1); when enable=0, every cycle is an apply event.
- commit while ARMED (no apply): re-snapshot, latest wins, stay ARMED.
- commit in same cycle as apply while ARMED: old snapshot applied, new snapshot captured, stay ARMED, busy stays 1, upd_done pulses.
- commit in IDLE during an event cycle: captured only; applied at next event, never the same one.
- Peak apply with new period < carrier: carrier continues counting down from old value; no clamp; next cycle obeys new period from zero.
- pwm[i] registered = (carrier < cmp_act[i]); cmp=0 -> constant 0; cmp > period_act -> constant 1. Compare is unsigned.

## Timing
- commit at cycle t -> busy=1 at t+1.
- Apply event at cycle t -> period_act/cmp_act updated at t+1, upd_done=1 at t+1 only, busy=0 at t+1 (unless re-committed).
- pwm lags carrier by one cycle; new cmp_act affects pwm from t+2.
- Carrier uses period_act of the current cycle; updated period governs from t+1.
- No backpressure; commit is never dropped.

## Configuration
- CPWM_UPD_PEAK_EN defined: upd_mode=1 makes peak events apply events too (double-update mode).
- Undefined: peak logic absent, upd_mode ignored, updates only at zero events (or continuously when stopped).

## Test plan
- Reset then commit period_sh=4, cmp_sh[0]=2, enable=0 -> period_act=4, cmp_act[0]=2, upd_done pulse two cycles after commit; carrier stays 0.
- enable=1, period_act=4 -> carrier 0,1,2,3,4,3,2,1,0 repeating, dir toggles at 4 and 0; pwm[0] high while carrier<2, one cycle delayed.
- Commit cmp_sh[0]=3 at carrier=2 rising, upd_mode=0 -> busy held until carrier=0, cmp_act[0]=3 next cycle, no change at peak.
- With CPWM_UPD_PEAK_EN, upd_mode=1, commit at carrier=1 rising -> applied at carrier=4 peak; without macro -> applied at next zero.
- Commit in the apply cycle while ARMED with values A then B -> A active, busy stays 1, B active after next zero.
- cmp_sh[1]=0 and cmp_sh[2]=5 with period 4 -> pwm[1] constantly 0, pwm[2] constantly 1; ARESETN low mid-ARMED -> all outputs 0, busy 0.

Source files
------------

// File: rtl/cpwm_update_sequencer.sv
// Symmetric up-down carrier with shadow snapshot and boundary-synchronous apply.
// Define CPWM_UPD_PEAK_EN to let upd_mode=1 also apply updates at carrier peaks.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no pending snapshot; active values are current
// ST_ARMED  | snapshot held, waiting for the next apply event
module cpwm_update_sequencer #(
    parameter int N_CH = 8,
    parameter int CW   = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 enable,
    input  logic                 upd_mode,
    input  logic [CW-1:0]        period_sh,
    input  logic [N_CH*CW-1:0]   cmp_sh,
    input  logic                 commit,
    output logic                 busy,
    output logic                 upd_done,
    output logic [CW-1:0]        carrier,
    output logic                 dir,
    output logic [CW-1:0]        period_act,
    output logic [N_CH*CW-1:0]   cmp_act,
    output logic [N_CH-1:0]      pwm
);

    typedef enum logic {ST_IDLE, ST_ARMED} state_t;

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [CW-1:0]        carrier_q, carrier_d;
    logic                 dir_q, dir_d;
    logic [CW-1:0]        period_act_q, period_act_d;
    logic [N_CH*CW-1:0]   cmp_act_q, cmp_act_d;
    logic [N_CH-1:0]      pwm_q, pwm_d;
    logic                 busy_q, busy_d;
    logic                 upd_done_q, upd_done_d;
    logic [CW-1:0]        snap_period_q, snap_period_d;
    logic [N_CH*CW-1:0]   snap_cmp_q, snap_cmp_d;

    logic evt_zero;
    logic apply_ev;

    assign evt_zero = enable && (carrier_q == '0);

`ifdef CPWM_UPD_PEAK_EN
    logic evt_peak;
    assign evt_peak = enable && (carrier_q == period_act_q) && !dir_q;
    assign apply_ev = !enable || evt_zero || (upd_mode && evt_peak);
`else
    logic unused_upd_mode;
    assign unused_upd_mode = upd_mode;
    assign apply_ev = !enable || evt_zero;
`endif

    always_comb begin
        carrier_d     = carrier_q;
        dir_d         = dir_q;
        period_act_d  = period_act_q;
        cmp_act_d     = cmp_act_q;
        pwm_d         = '0;
        upd_done_d    = 1'b0;
        snap_period_d = snap_period_q;
        snap_cmp_d    = snap_cmp_q;
        state_d       = state_q;

        // Carrier: the down leg never looks at the period, so a shrinking
        // period applied at the peak just lets the count run down to zero.
        if (!enable || period_act_q == '0) begin
            carrier_d = '0;
            dir_d     = 1'b0;
        end else if (!dir_q) begin
            if (carrier_q >= period_act_q) begin
                carrier_d = carrier_q - ONE;
                dir_d     = 1'b1;
            end else begin
                carrier_d = carrier_q + ONE;
            end
        end else begin
            if (carrier_q == '0) begin
                carrier_d = ONE;
                dir_d     = 1'b0;
            end else begin
                carrier_d = carrier_q - ONE;
            end
        end

        for (int i = 0; i < N_CH; i++) begin
            pwm_d[i] = carrier_q < cmp_act_q[i*CW +: CW];
        end

        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    snap_period_d = period_sh;
                    snap_cmp_d    = cmp_sh;
                    state_d       = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (apply_ev) begin
                    period_act_d = snap_period_q;
                    cmp_act_d    = snap_cmp_q;
                    upd_done_d   = 1'b1;
                    state_d      = ST_IDLE;
                end
                // A commit landing on the apply cycle re-arms with the new values.
                if (commit) begin
                    snap_period_d = period_sh;
                    snap_cmp_d    = cmp_sh;
                    state_d       = ST_ARMED;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_ARMED);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q       <= ST_IDLE;
            carrier_q     <= '0;
            dir_q         <= 1'b0;
            period_act_q  <= '0;
            cmp_act_q     <= '0;
            pwm_q         <= '0;
            busy_q        <= 1'b0;
            upd_done_q    <= 1'b0;
            snap_period_q <= '0;
            snap_cmp_q    <= '0;
        end else begin
            state_q       <= state_d;
            carrier_q     <= carrier_d;
            dir_q         <= dir_d;
            period_act_q  <= period_act_d;
            cmp_act_q     <= cmp_act_d;
            pwm_q         <= pwm_d;
            busy_q        <= busy_d;
            upd_done_q    <= upd_done_d;
            snap_period_q <= snap_period_d;
            snap_cmp_q    <= snap_cmp_d;
        end
    end

    assign carrier    = carrier_q;
    assign dir        = dir_q;
    assign period_act = period_act_q;
    assign cmp_act    = cmp_act_q;
    assign pwm        = pwm_q;
    assign busy       = busy_q;
    assign upd_done   = upd_done_q;

endmodule

// File: tb/tb_cpwm_update_sequencer.sv
// Bench for cpwm_update_sequencer: vector table through a scoreboard queue,
// then hand-written sequences for peak/zero apply, re-commit and reset corners.
module tb_cpwm_update_sequencer;

    localparam int N_CH = 8;
    localparam int CW   = 16;
    localparam int SW   = CW + 3 + CW + N_CH*CW + N_CH;

    logic                ACLK = 1'b0;
    logic                ARESETN = 1'b0;
    logic                enable = 1'b0;
    logic                upd_mode = 1'b0;
    logic [CW-1:0]       period_sh = '0;
    logic [N_CH*CW-1:0]  cmp_sh = '0;
    logic                commit = 1'b0;
    logic                busy;
    logic                upd_done;
    logic [CW-1:0]       carrier;
    logic                dir;
    logic [CW-1:0]       period_act;
    logic [N_CH*CW-1:0]  cmp_act;
    logic [N_CH-1:0]     pwm;

    cpwm_update_sequencer #(.N_CH(N_CH), .CW(CW)) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .enable     (enable),
        .upd_mode   (upd_mode),
        .period_sh  (period_sh),
        .cmp_sh     (cmp_sh),
        .commit     (commit),
        .busy       (busy),
        .upd_done   (upd_done),
        .carrier    (carrier),
        .dir        (dir),
        .period_act (period_act),
        .cmp_act    (cmp_act),
        .pwm        (pwm)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic            rstn, en, mode, cmt;
        logic [CW-1:0]   per, c0, c1, c2;
        logic [CW-1:0]   e_car;
        logic            e_dir, e_busy, e_done;
        logic [CW-1:0]   e_per, e_c0, e_c1, e_c2;
        logic [N_CH-1:0] e_pwm;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[17];
    vec_t exp_q[$];

    function automatic vec_t mk(input int rstn, input int en, input int mode, input int cmt,
                                input int per, input int c0, input int c1, input int c2,
                                input int car, input int dr, input int bsy, input int dn,
                                input int eper, input int ec0, input int ec1, input int ec2,
                                input int epwm);
        vec_t v;
        v.rstn = (rstn != 0); v.en = (en != 0); v.mode = (mode != 0); v.cmt = (cmt != 0);
        v.per = CW'(per); v.c0 = CW'(c0); v.c1 = CW'(c1); v.c2 = CW'(c2);
        v.e_car = CW'(car); v.e_dir = (dr != 0); v.e_busy = (bsy != 0); v.e_done = (dn != 0);
        v.e_per = CW'(eper); v.e_c0 = CW'(ec0); v.e_c1 = CW'(ec1); v.e_c2 = CW'(ec2);
        v.e_pwm = N_CH'(epwm);
        return v;
    endfunction

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ARESETN   = v.rstn;
        enable    = v.en;
        upd_mode  = v.mode;
        commit    = v.cmt;
        period_sh = v.per;
        cmp_sh    = '0;
        cmp_sh[0*CW +: CW] = v.c0;
        cmp_sh[1*CW +: CW] = v.c1;
        cmp_sh[2*CW +: CW] = v.c2;
        exp_q.push_back(v);
    endtask

    task automatic check_vec(input int idx);
        vec_t e;
        logic [SW-1:0] got_s, exp_s;
        step();
        e = exp_q.pop_front();
        got_s = {carrier, dir, busy, upd_done, period_act, cmp_act, pwm};
        exp_s = {e.e_car, e.e_dir, e.e_busy, e.e_done, e.e_per,
                 {((N_CH-3)*CW){1'b0}}, e.e_c2, e.e_c1, e.e_c0, e.e_pwm};
        n_checks++;
        if (got_s !== exp_s) begin
            n_fail++;
            $display("FAIL vec%0d: got car=%0d dir=%0b busy=%0b done=%0b per=%0d cmp=%0d/%0d/%0d pwm=%h, expected car=%0d dir=%0b busy=%0b done=%0b per=%0d cmp=%0d/%0d/%0d pwm=%h",
                     idx, carrier, dir, busy, upd_done, period_act,
                     cmp_act[0*CW +: CW], cmp_act[1*CW +: CW], cmp_act[2*CW +: CW], pwm,
                     e.e_car, e.e_dir, e.e_busy, e.e_done, e.e_per, e.e_c0, e.e_c1, e.e_c2, e.e_pwm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int car_seq[5] = '{1, 2, 1, 0, 1};

        //            rst en md cm per c0 c1 c2 | car dir bsy dn per c0 c1 c2 pwm
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 'h00);
        tbl[1]  = mk(1, 0, 0, 1, 4, 2, 0, 5,   0, 0, 1, 0, 0, 0, 0, 0, 'h00);
        tbl[2]  = mk(1, 0, 0, 0, 4, 2, 0, 5,   0, 0, 0, 1, 4, 2, 0, 5, 'h00);
        tbl[3]  = mk(1, 0, 0, 0, 4, 2, 0, 5,   0, 0, 0, 0, 4, 2, 0, 5, 'h05);
        tbl[4]  = mk(1, 1, 0, 0, 4, 2, 0, 5,   1, 0, 0, 0, 4, 2, 0, 5, 'h05);
        tbl[5]  = mk(1, 1, 0, 0, 4, 2, 0, 5,   2, 0, 0, 0, 4, 2, 0, 5, 'h05);
        tbl[6]  = mk(1, 1, 0, 1, 4, 3, 0, 5,   3, 0, 1, 0, 4, 2, 0, 5, 'h04);
        tbl[7]  = mk(1, 1, 0, 0, 4, 3, 0, 5,   4, 0, 1, 0, 4, 2, 0, 5, 'h04);
        tbl[8]  = mk(1, 1, 0, 0, 4, 3, 0, 5,   3, 1, 1, 0, 4, 2, 0, 5, 'h04);
        tbl[9]  = mk(1, 1, 0, 0, 4, 3, 0, 5,   2, 1, 1, 0, 4, 2, 0, 5, 'h04);
        tbl[10] = mk(1, 1, 0, 0, 4, 3, 0, 5,   1, 1, 1, 0, 4, 2, 0, 5, 'h04);
        tbl[11] = mk(1, 1, 0, 0, 4, 3, 0, 5,   0, 1, 1, 0, 4, 2, 0, 5, 'h05);
        tbl[12] = mk(1, 1, 0, 0, 4, 3, 0, 5,   1, 0, 0, 1, 4, 3, 0, 5, 'h05);
        tbl[13] = mk(1, 1, 0, 0, 4, 3, 0, 5,   2, 0, 0, 0, 4, 3, 0, 5, 'h05);
        tbl[14] = mk(1, 1, 0, 0, 4, 3, 0, 5,   3, 0, 0, 0, 4, 3, 0, 5, 'h05);
        tbl[15] = mk(1, 1, 0, 0, 4, 3, 0, 5,   4, 0, 0, 0, 4, 3, 0, 5, 'h04);
        tbl[16] = mk(1, 1, 0, 0, 4, 3, 0, 5,   3, 1, 0, 0, 4, 3, 0, 5, 'h04);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i]);
            check_vec(i);
        end

        // Peak-vs-zero apply: commit on the rising carrier=1 cycle.
        upd_mode = 1'b1;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            if (carrier == 1 && dir == 1'b0) begin found = 1; break; end
            step();
        end
        check("seqA_sync", found, 1);
        cmp_sh[0 +: CW] = 1;
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("seqA_busy", int'(busy), 1);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (upd_done) begin found = 1; break; end
        end
        check("seqA_done_seen", found, 1);
`ifdef CPWM_UPD_PEAK_EN
        check("seqA_car_at_done", int'(carrier), 3);
        check("seqA_dir_at_done", int'(dir), 1);
`else
        check("seqA_car_at_done", int'(carrier), 1);
        check("seqA_dir_at_done", int'(dir), 0);
`endif
        check("seqA_cmp0", int'(cmp_act[0 +: CW]), 1);
        check("seqA_busy_clr", int'(busy), 0);
        upd_mode = 1'b0;

        // Re-commit on the apply cycle: A goes live, B stays armed.
        found = 0;
        for (int k = 0; k < 40; k++) begin
            if (carrier == 2 && dir == 1'b1) begin found = 1; break; end
            step();
        end
        check("seqB_sync", found, 1);
        cmp_sh[0 +: CW] = 2;
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("seqB_armed", int'(busy), 1);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (carrier == 0) begin found = 1; break; end
            step();
        end
        check("seqB_zero_seen", found, 1);
        cmp_sh[0 +: CW] = 4;
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("seqB_done_A", int'(upd_done), 1);
        check("seqB_busy_kept", int'(busy), 1);
        check("seqB_cmp0_A", int'(cmp_act[0 +: CW]), 2);
        check("seqB_car", int'(carrier), 1);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (upd_done) begin found = 1; break; end
        end
        check("seqB_done_B_seen", found, 1);
        check("seqB_cmp0_B", int'(cmp_act[0 +: CW]), 4);
        check("seqB_busy_clr", int'(busy), 0);
        check("seqB_car_B", int'(carrier), 1);

        // Reset while armed discards everything.
        found = 0;
        for (int k = 0; k < 40; k++) begin
            if (carrier == 2 && dir == 1'b0) begin found = 1; break; end
            step();
        end
        check("seqD_sync", found, 1);
        cmp_sh[0 +: CW] = 3;
        period_sh = 2;
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("seqD_armed", int'(busy), 1);
        ARESETN = 1'b0;
        step();
        check("seqD_rst_zero",
              int'(|{carrier, dir, busy, upd_done, period_act, cmp_act, pwm}), 0);
        ARESETN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("seqD_car_held", int'(carrier), 0);
            check("seqD_per_zero", int'(period_act), 0);
            check("seqD_not_busy", int'(busy), 0);
        end

        // Period 0 running: every cycle is a zero event, so apply is immediate.
        period_sh = 2;
        cmp_sh[0 +: CW] = 1;
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("seqE_busy", int'(busy), 1);
        check("seqE_no_done", int'(upd_done), 0);
        step();
        check("seqE_done", int'(upd_done), 1);
        check("seqE_per", int'(period_act), 2);
        check("seqE_car0", int'(carrier), 0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("seqE_carrier", int'(carrier), car_seq[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
